// File: rtl/rs_dec_arbiter.sv
// rs_dec_arbiter: round-robin arbiter sharing one RS decoder between two requesters, one job in flight.
// Optional macro RS_DEC_ARBITER_STATS_EN adds saturating per-requester grant counters.
module rs_dec_arbiter #(
    parameter int DEC_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [20:0] req0_codeword,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [20:0] req1_codeword,
    output logic        req1_ready,
    output logic        dec_enable,
    output logic [20:0] dec_codeword,
    input  logic [8:0]  dec_decoded,
    output logic        out_valid,
    output logic [8:0]  out_data,
    output logic        out_id,
`ifdef RS_DEC_ARBITER_STATS_EN
    output logic [7:0]  grant_cnt0,
    output logic [7:0]  grant_cnt1,
`endif
    input  logic        out_ready
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state, state_nxt;
    logic rr_ptr;
    logic [3:0] cnt;
    logic any_req, gnt;
    assign any_req = req0_valid || req1_valid;
    // rr_ptr only breaks ties; a lone requester always wins
    assign gnt = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nxt;
    end
    always_comb begin
        state_nxt = (state == IDLE)  ? (any_req ? ISSUE : IDLE) :
                    (state == ISSUE) ? WAIT :
                    (state == WAIT)  ? ((cnt == 4'd1) ? DONE : WAIT) :
                                       (out_ready ? IDLE : DONE);
    end
    // reset gates the strobes combinationally so it wins within its own cycle
    always_comb begin
        req0_ready = !reset && state == IDLE && any_req && !gnt;
        req1_ready = !reset && state == IDLE && any_req && gnt;
        dec_enable = !reset && state == ISSUE;
        out_valid  = !reset && state == DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr       <= 1'b0;
            cnt          <= 4'd0;
            dec_codeword <= 21'd0;
            out_data     <= 9'd0;
            out_id       <= 1'b0;
        end else begin
            if (req0_ready || req1_ready) begin
                dec_codeword <= gnt ? req1_codeword : req0_codeword;
                out_id       <= gnt;
            end
            if (state == ISSUE)
                cnt <= 4'(DEC_LAT);
            else if (state == WAIT)
                cnt <= cnt - 4'd1;
            if (state == WAIT && cnt == 4'd1)
                out_data <= dec_decoded;
            if (out_valid && out_ready)
                rr_ptr <= ~out_id;
        end
    end
`ifdef RS_DEC_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0 <= 8'd0;
            grant_cnt1 <= 8'd0;
        end else begin
            grant_cnt0 <= (req0_ready && grant_cnt0 != 8'hff) ? grant_cnt0 + 8'd1 : grant_cnt0;
            grant_cnt1 <= (req1_ready && grant_cnt1 != 8'hff) ? grant_cnt1 + 8'd1 : grant_cnt1;
        end
    end
`endif
endmodule

// File: tb/tb_rs_dec_arbiter.sv
// tb_rs_dec_arbiter: directed checks of grant timing, round-robin order, stall, abort on reset.
// Define RS_DEC_ARBITER_STATS_EN to also check the grant counters.
module tb_rs_dec_arbiter;
    logic        clk = 0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [20:0] req0_codeword, req1_codeword, dec_codeword;
    logic        dec_enable, out_valid, out_id, out_ready;
    logic [8:0]  dec_decoded, out_data, dec_xor;
`ifdef RS_DEC_ARBITER_STATS_EN
    logic [7:0]  grant_cnt0, grant_cnt1;
`endif
    int n_chk = 0, n_pass = 0, n;
    logic exp_id [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    always #5 clk = ~clk;
    // stand-in decoder: low nine bits of the codeword xor a bench-chosen mask
    assign dec_decoded = dec_codeword[8:0] ^ dec_xor;
    rs_dec_arbiter #(.DEC_LAT(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_codeword(req0_codeword), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_codeword(req1_codeword), .req1_ready(req1_ready),
        .dec_enable(dec_enable), .dec_codeword(dec_codeword), .dec_decoded(dec_decoded),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
`ifdef RS_DEC_ARBITER_STATS_EN
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
        .out_ready(out_ready)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %h expected %h", tag, got, exp);
    endtask
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask
    initial begin
        reset = 1; req0_valid = 1; req0_codeword = 21'h0; req1_valid = 0; req1_codeword = 21'h0;
        out_ready = 1; dec_xor = 9'h0;
        repeat (2) begin
            cyc;
            chk("rst_rdy0", req0_ready, 0);
            chk("rst_en", dec_enable, 0);
            chk("rst_ov", out_valid, 0);
        end
        reset = 0; #1;
        chk("first_grant", req0_ready, 1);
        chk("grant_no_en", dec_enable, 0);
        cyc; req0_valid = 0; #1;
        chk("issue_en", dec_enable, 1);
        chk("issue_rdy", req0_ready, 0);
        repeat (4) begin
            cyc;
            chk("wait_ov", out_valid, 0);
            chk("wait_en", dec_enable, 0);
        end
        cyc;
        chk("lat_ov", out_valid, 1);
        chk("lat_id", out_id, 0);
        chk("lat_data", out_data, 9'h000);
        cyc;
        chk("hs_ov", out_valid, 0);
        req1_valid = 1; req1_codeword = 21'h0AB1A5; out_ready = 0; #1;
        chk("stall_grant1", req1_ready, 1);
        chk("stall_grant0", req0_ready, 0);
        cyc;
        chk("stall_cw", dec_codeword, 21'h0AB1A5);
        chk("stall_issue_rdy", req1_ready, 0);
        repeat (4) begin
            cyc;
            chk("stall_wait_rdy", req1_ready, 0);
        end
        repeat (10) begin
            cyc;
            chk("stall_ov", out_valid, 1);
            chk("stall_data", out_data, 9'h1A5);
            chk("stall_id", out_id, 1);
            chk("stall_rdy", req1_ready, 0);
        end
        out_ready = 1; req1_valid = 0; #1;
        chk("stall_hs_ov", out_valid, 1);
        cyc;
        chk("post_hs_ov", out_valid, 0);
        chk("post_hs_rdy", req1_ready, 0);
        req0_valid = 1; req0_codeword = 21'h1FFFFF; #1;
        chk("c_grant0", req0_ready, 1);
        cyc; req0_valid = 0;
        repeat (4) cyc;
        cyc;
        chk("c_ov", out_valid, 1);
        chk("c_data", out_data, 9'h1FF);
        chk("c_id", out_id, 0);
        cyc;
        chk("c_hs_ov", out_valid, 0);
        req0_valid = 1; req1_valid = 1; #1;
        chk("rr_grant1", req1_ready, 1);
        chk("rr_grant0", req0_ready, 0);
        cyc; cyc; cyc;
        reset = 1; #1;
        chk("abort_ov", out_valid, 0);
        cyc;
        reset = 0; req0_codeword = 21'h000123; req1_codeword = 21'h0000C7; dec_xor = 9'h0F0; #1;
        chk("abort_idle_ov", out_valid, 0);
        chk("abort_rr_rdy1", req1_ready, 0);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(req0_ready || req1_ready) && n < 20) begin
                cyc;
                n++;
            end
            chk("rr_grant_seen", {31'd0, req0_ready | req1_ready}, 1);
            chk("rr_grant_who", req1_ready, exp_id[k]);
            chk("rr_no_double", req0_ready & req1_ready, 0);
            n = 0;
            do begin
                cyc;
                n++;
                if (n > 1 && (req0_ready || req1_ready)) chk("rr_ready_in_job", 1, 0);
            end while (!out_valid && n < 20);
            chk("rr_ov_seen", out_valid, 1);
            chk("rr_lat", n, 6);
            chk("rr_id", out_id, exp_id[k]);
            chk("rr_data", out_data, exp_id[k] ? 9'h037 : 9'h1D3);
            cyc;
        end
`ifdef RS_DEC_ARBITER_STATS_EN
        reset = 1; req0_valid = 0; req1_valid = 1; out_ready = 1;
        cyc; cyc;
        reset = 0;
        n = 0;
        for (int c = 0; c < 3000 && n < 300; c++) begin
            #1;
            if (req1_ready) n++;
            cyc;
        end
        chk("stats_grants", n, 300);
        chk("stats_cnt1", grant_cnt1, 8'd255);
        chk("stats_cnt0", grant_cnt0, 8'd0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rs_dec_arbiter.md
RS_DEC_ARBITER -- requirements
Module: rs_dec_arbiter

Interface
REQ-001 Parameter DEC_LAT, default 4, decoder latency in cycles from dec_enable pulse to valid dec_decoded; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has a codeword pending.
REQ-005 req0_codeword  input  21  requester 0 codeword, seven 3-bit GF(8) symbols.
REQ-006 req0_ready  output  1  one-cycle acceptance strobe for requester 0.
REQ-007 req1_valid / req1_codeword / req1_ready  input/input/output  1/21/1  same as REQ-004..006 for requester 1.
REQ-008 dec_enable  output  1  one-cycle start pulse to the shared RS decoder.
REQ-009 dec_codeword  output  21  codeword driven to the decoder; held stable from ISSUE through end of WAIT.
REQ-010 dec_decoded  input  9  decoder result, three 3-bit symbols.
REQ-011 out_valid  output  1  decoded result available.
REQ-012 out_data  output  9  decoded message.
REQ-013 out_id  output  1  index of requester that owns out_data.
REQ-014 out_ready  input  1  consumer accepts out_data when high with out_valid.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; exactly one job in flight.
REQ-016 IDLE: if neither valid, stay; if one valid, grant it; if both valid, grant the requester indicated by rr_ptr.
REQ-017 Grant cycle: assert granted reqN_ready for exactly one cycle, latch its codeword into dec_codeword, latch id, go to ISSUE.
REQ-018 ISSUE: dec_enable=1 for exactly one cycle, load wait counter with DEC_LAT, go to WAIT.
REQ-019 WAIT: decrement counter each cycle; on the cycle counter reaches 1, capture dec_decoded into out_data and go to DONE.
REQ-020 Grant-to-out_valid latency SHALL be DEC_LAT+2 cycles.
REQ-021 DONE: out_valid=1, out_data/out_id held stable; on out_valid&&out_ready go to IDLE with out_valid low the next cycle.
REQ-022 rr_ptr SHALL toggle to the non-granted requester on every completed handshake in DONE; with one requester active, it may be served back-to-back.
REQ-023 reqN_ready SHALL never assert outside the IDLE grant cycle; req valids deasserting mid-job SHALL not affect the job in flight.
REQ-024 Back-to-back: earliest next grant is the cycle after DONE handshake (min throughput one job per DEC_LAT+3 cycles).
REQ-025 out_ready high while out_valid low SHALL be ignored.

Reset
REQ-026 On reset: state=IDLE, rr_ptr=0, counter=0, dec_enable=0, dec_codeword=0, req0_ready=req1_ready=0, out_valid=0, out_data=0, out_id=0.
REQ-027 Reset asserted in any state SHALL abort the in-flight job with no out_valid emitted; reset has priority over all other inputs.

Configuration
REQ-028 Macro RS_DEC_ARBITER_STATS_EN, when defined, SHALL add outputs grant_cnt0 and grant_cnt1 (8 bits each), incremented per grant, saturating at 255, cleared by reset.
REQ-029 Without RS_DEC_ARBITER_STATS_EN these ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-030 Reset held 2 cycles with req0_valid=1 -> no ready, dec_enable=0, out_valid=0; first grant the cycle after reset deasserts.
REQ-031 DEC_LAT=4, req0 only, codeword 21'h0 with decoder returning 9'h000, out_ready=1 -> req0_ready at cycle t, dec_enable at t+1, out_valid at t+6, out_id=0.
REQ-032 Both valid continuously, out_ready=1, 4 jobs -> grant order 0,1,0,1; out_id matches; no double ready.
REQ-033 out_ready held low 10 cycles in DONE -> out_valid and out_data (e.g. 9'h1A5) stable all 10 cycles, no new grant.
REQ-034 Reset asserted in WAIT -> FSM IDLE next cycle, out_valid never rises for aborted job, rr_ptr=0.
REQ-035 With RS_DEC_ARBITER_STATS_EN, 300 grants to req1 -> grant_cnt1=255, grant_cnt0=0.
